sha2_pad_ctrl: RTL and testbench
================================

Name: sha2_pad_ctrl

Overview:
- Control unit that drives the SHA-2 input datapath (packet register file, index counter, message-length register). It sits directly upstream of that datapath.
- Accepts a stream of 64-bit message words through a valid/ready handshake and generates st_pkt, clr, pad_pkt, zero_pkt and mgln_pkt.
- Sequences the padding: pad word, zero fill, then the length word in the last slot.
- Signals each completed 512-bit block to the compression stage and holds until that stage acknowledges it.

Parameters:
- reg_cnt, 8, 64-bit slots per block; always equals 2**dec_w.
- dec_w, 3, width of the datapath slot index idx.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_b  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse; begins a new message; ignored unless in IDLE.
- pkt_vld  input  1  upstream word valid; the word itself goes directly to the datapath pkt port.
- pkt_last  input  1  qualifies pkt_vld; marks the accepted word as the final message word.
- pkt_rdy  output  1  controller accepts a word this cycle.
- idx  input  dec_w  current slot index from the datapath counter.
- st_pkt  output  1  store the current datapath word into slot idx; also advances idx.
- clr  output  1  clears the datapath index counter and length register.
- pad_pkt  output  1  selects the pad word 0x8000_0000_0000_0000.
- zero_pkt  output  1  selects an all-zero word.
- mgln_pkt  output  1  selects the message-length word.
- blk_vld  output  1  blk holds a complete block.
- blk_last  output  1  valid with blk_vld; block contains the length word.
- blk_ack  input  1  consumer has taken the block.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst_b=0, asynchronous): state=IDLE, ret=MSG, last_f=0. All outputs 0.
- Outputs are Moore, decoded from state, except:
  - pkt_rdy = (state==MSG).
  - In MSG, st_pkt = pkt_vld & pkt_rdy.
- States and transitions:
  - IDLE: start -> CLR.
  - CLR: clr=1 for exactly one cycle -> MSG.
  - MSG: on an accepted word (st_pkt=1):
    - idx==reg_cnt-1 and pkt_last=0 -> BLK, ret=MSG.
    - idx==reg_cnt-1 and pkt_last=1 -> BLK, ret=PAD.
    - pkt_last=1 and idx<reg_cnt-1 -> PAD.
    - otherwise stay in MSG.
    - No accepted word: stay in MSG; no outputs asserted.
  - PAD: st_pkt=1, pad_pkt=1 for one cycle.
    - idx==reg_cnt-1 -> BLK, ret=ZERO.
    - idx==reg_cnt-2 -> LEN.
    - otherwise -> ZERO.
  - ZERO: st_pkt=1, zero_pkt=1 each cycle; when idx==reg_cnt-2 -> LEN.
  - LEN: st_pkt=1, mgln_pkt=1 with idx==reg_cnt-1; set last_f=1 -> BLK.
  - BLK: blk_vld=1, blk_last=last_f; st_pkt=0, pkt_rdy=0.
    - blk_ack sampled high -> IDLE if last_f (last_f cleared), else -> ret.
    - blk_ack low while outside BLK is ignored.
- Slot index wrap (reg_cnt-1 -> 0) is done by the datapath counter on st_pkt; the controller never asserts clr within a message.
- At most one of pad_pkt/zero_pkt/mgln_pkt is high; each is high only together with st_pkt.
- Every message contains at least one word; pkt_last without pkt_vld has no effect.
- start outside IDLE: ignored.
- Simultaneous start and blk_ack in the final BLK: the controller goes to IDLE; that start is lost.
- Latency:
  - Final word accepted at slot k<reg_cnt-2: blk_vld rises reg_cnt-k cycles later.
  - Final word at slot reg_cnt-2: pad at reg_cnt-1, then a second, zero-filled block.

Optional Feature:
- Macro SHA2_PADCTRL_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in any state other than IDLE -> next state CLR (clr pulse, datapath cleared), then IDLE instead of MSG; last_f cleared.
  - abort has priority over all other transitions.
  - Any pending block is discarded; blk_vld drops the next cycle.
- Not defined: the port does not exist and behaviour is exactly as above.

Test Plan:
- Reset: rst_b=0 mid-ZERO -> all outputs 0 immediately, before the next clk edge. Release, then start -> clr=1 one cycle, then pkt_rdy=1.
- 3-word message (last on word 3) -> st_pkt on idx 0,1,2 data; pad_pkt at idx3; zero_pkt at idx4,5,6; mgln_pkt at idx7. Then blk_vld=1, blk_last=1; ack -> IDLE, busy=0.
- 6-word message -> pad_pkt at idx6, mgln_pkt at idx7, no zero_pkt cycle; one block with blk_last=1.
- 7-word message -> pad_pkt at idx7; block 1 blk_vld=1, blk_last=0. Ack -> zero_pkt at idx0..6, mgln_pkt at idx7; block 2 blk_last=1.
- 10-word message with pkt_vld low on alternate cycles; blk_ack held low 3 cycles after the first block:
  - pkt_rdy=0, st_pkt=0 and blk_vld=1 for those 3 cycles.
  - Words 9-10 land at idx 0,1; pad at idx2.
- With SHA2_PADCTRL_ABORT_EN: abort during MSG at idx4 -> clr=1 next cycle, then IDLE. A new 3-word message then repeats scenario 2 exactly.

Source files
------------

// File: rtl/sha2_pad_ctrl.sv
// rtl/sha2_pad_ctrl.sv - SHA-2 message padding sequencer for the packet/index/length datapath
// Optional abort input enabled by SHA2_PADCTRL_ABORT_EN.
module sha2_pad_ctrl #(
  parameter int reg_cnt = 8,
  parameter int dec_w   = 3
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             pkt_vld,
  input  logic             pkt_last,
  output logic             pkt_rdy,
  input  logic [dec_w-1:0] idx,
  output logic             st_pkt,
  output logic             clr,
  output logic             pad_pkt,
  output logic             zero_pkt,
  output logic             mgln_pkt,
  output logic             blk_vld,
  output logic             blk_last,
  input  logic             blk_ack,
`ifdef SHA2_PADCTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_MSG, S_PAD, S_ZERO, S_LEN, S_BLK
  } state_t;

  localparam logic [dec_w-1:0] IDX_LAST = dec_w'(reg_cnt - 1);
  localparam logic [dec_w-1:0] IDX_PEN  = dec_w'(reg_cnt - 2);

  state_t state_q, state_d;
  state_t ret_q, ret_d;
  logic   last_f_q, last_f_d;
`ifdef SHA2_PADCTRL_ABORT_EN
  logic   abort_q, abort_d;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= S_IDLE;
      ret_q    <= S_MSG;
      last_f_q <= 1'b0;
`ifdef SHA2_PADCTRL_ABORT_EN
      abort_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      last_f_q <= last_f_d;
`ifdef SHA2_PADCTRL_ABORT_EN
      abort_q  <= abort_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    last_f_d = last_f_q;
`ifdef SHA2_PADCTRL_ABORT_EN
    abort_d  = abort_q;
`endif
    case (state_q)
      S_IDLE: if (start) state_d = S_CLR;
      S_CLR: begin
        state_d = S_MSG;
`ifdef SHA2_PADCTRL_ABORT_EN
        if (abort_q) state_d = S_IDLE;
        abort_d = 1'b0;
`endif
      end
      S_MSG: begin
        // pkt_rdy is high throughout MSG, so pkt_vld alone means a word is taken
        if (pkt_vld) begin
          if (idx == IDX_LAST) begin
            state_d = S_BLK;
            ret_d   = pkt_last ? S_PAD : S_MSG;
          end else if (pkt_last) begin
            state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        if (idx == IDX_LAST) begin
          state_d = S_BLK;
          ret_d   = S_ZERO;
        end else if (idx == IDX_PEN) begin
          state_d = S_LEN;
        end else begin
          state_d = S_ZERO;
        end
      end
      S_ZERO: if (idx == IDX_PEN) state_d = S_LEN;
      S_LEN: begin
        last_f_d = 1'b1;
        state_d  = S_BLK;
      end
      S_BLK: begin
        if (blk_ack) begin
          if (last_f_q) begin
            state_d  = S_IDLE;
            last_f_d = 1'b0;
          end else begin
            state_d = ret_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SHA2_PADCTRL_ABORT_EN
    // abort overrides everything; CLR then returns to IDLE instead of MSG
    if (abort && state_q != S_IDLE) begin
      state_d  = S_CLR;
      ret_d    = S_MSG;
      last_f_d = 1'b0;
      abort_d  = 1'b1;
    end
`endif
  end

  always_comb begin
    pkt_rdy  = 1'b0;
    st_pkt   = 1'b0;
    clr      = 1'b0;
    pad_pkt  = 1'b0;
    zero_pkt = 1'b0;
    mgln_pkt = 1'b0;
    blk_vld  = 1'b0;
    blk_last = 1'b0;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_CLR: clr = 1'b1;
      S_MSG: begin
        pkt_rdy = 1'b1;
        st_pkt  = pkt_vld;
      end
      S_PAD: begin
        st_pkt  = 1'b1;
        pad_pkt = 1'b1;
      end
      S_ZERO: begin
        st_pkt   = 1'b1;
        zero_pkt = 1'b1;
      end
      S_LEN: begin
        st_pkt   = 1'b1;
        mgln_pkt = 1'b1;
      end
      S_BLK: begin
        blk_vld  = 1'b1;
        blk_last = last_f_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sha2_pad_ctrl.sv
// tb/tb_sha2_pad_ctrl.sv - scoreboard bench for sha2_pad_ctrl with a model of the datapath index counter
module tb_sha2_pad_ctrl;
  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       start = 1'b0;
  logic       pkt_vld = 1'b0;
  logic       pkt_last = 1'b0;
  logic       blk_ack = 1'b0;
`ifdef SHA2_PADCTRL_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic [2:0] idx;
  logic       pkt_rdy, st_pkt, clr, pad_pkt, zero_pkt, mgln_pkt, blk_vld, blk_last, busy;

  int n_chk = 0;
  int n_pass = 0;
  int exp_st[$];   // kind*8 + idx; kind 0=data 1=pad 2=zero 3=len
  int exp_blk[$];  // expected blk_last per block
  int stall_n = 0;

  sha2_pad_ctrl #(.reg_cnt(8), .dec_w(3)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .pkt_vld(pkt_vld), .pkt_last(pkt_last),
    .pkt_rdy(pkt_rdy), .idx(idx), .st_pkt(st_pkt), .clr(clr), .pad_pkt(pad_pkt),
    .zero_pkt(zero_pkt), .mgln_pkt(mgln_pkt), .blk_vld(blk_vld), .blk_last(blk_last),
    .blk_ack(blk_ack),
`ifdef SHA2_PADCTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // datapath slot counter: cleared by clr, advanced by st_pkt
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) idx <= 3'd0;
    else if (clr) idx <= 3'd0;
    else if (st_pkt) idx <= idx + 3'd1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic push_msg(input int n);
    int pos;
    for (int i = 0; i < n; i++) begin
      exp_st.push_back(i % 8);
      if (i % 8 == 7) exp_blk.push_back(0);
    end
    pos = n % 8;
    exp_st.push_back(8 + pos);
    if (pos == 7) begin
      exp_blk.push_back(0);
      for (int s = 0; s < 7; s++) exp_st.push_back(16 + s);
    end else begin
      for (int s = pos + 1; s < 7; s++) exp_st.push_back(16 + s);
    end
    exp_st.push_back(24 + 7);
    exp_blk.push_back(1);
  endtask

  // monitor: compares every store and every new block against the queues
  initial begin
    int   code;
    int   kind;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_b) begin
        prev = 1'b0;
      end else begin
        if (!st_pkt && (pad_pkt || zero_pkt || mgln_pkt)) chk("sel_without_st", 1, 0);
        if (st_pkt) begin
          case ({pad_pkt, zero_pkt, mgln_pkt})
            3'b000:  kind = 0;
            3'b100:  kind = 1;
            3'b010:  kind = 2;
            3'b001:  kind = 3;
            default: kind = 7;
          endcase
          code = kind * 8 + int'(idx);
          if (exp_st.size() == 0) chk("st_unexpected", code, -1);
          else chk("st_slot", code, exp_st.pop_front());
        end
        if (blk_vld && !prev) begin
          if (exp_blk.size() == 0) chk("blk_unexpected", 1, 0);
          else chk("blk_last", int'(blk_last), exp_blk.pop_front());
        end
        prev = blk_vld;
      end
    end
  end

  // block consumer: acks each block, optionally holding off for stall_n cycles
  initial begin
    forever begin
      @(negedge clk);
      if (rst_b && blk_vld) begin
        if (stall_n > 0) begin
          blk_ack = 1'b0;
          for (int j = 0; j < stall_n; j++) begin
            @(negedge clk);
            chk("stall_blk_vld", int'(blk_vld), 1);
            chk("stall_pkt_rdy", int'(pkt_rdy), 0);
            chk("stall_st_pkt", int'(st_pkt), 0);
          end
          stall_n = 0;
        end
        blk_ack = 1'b1;
      end else begin
        blk_ack = 1'b0;
      end
    end
  end

  task automatic start_msg();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clr_pulse", int'(clr), 1);
    chk("clr_rdy_low", int'(pkt_rdy), 0);
    chk("clr_busy", int'(busy), 1);
    @(negedge clk);
    chk("clr_one_cycle", int'(clr), 0);
    chk("msg_rdy", int'(pkt_rdy), 1);
  endtask

  task automatic send_words(input int n, input int gap, input bit with_last);
    int tmo;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        pkt_vld = 1'b0;
        pkt_last = 1'b0;
        repeat (gap) @(negedge clk);
      end
      pkt_vld  = 1'b1;
      pkt_last = with_last && (i == n - 1);
      tmo = 0;
      while (!pkt_rdy && tmo < 100) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 100) chk("word_timeout", 0, 1);
      @(negedge clk);
    end
    pkt_vld  = 1'b0;
    pkt_last = 1'b0;
  endtask

  task automatic wait_idle();
    int tmo;
    tmo = 0;
    while (busy && tmo < 300) begin
      @(negedge clk);
      tmo++;
    end
    #2;
    chk("end_busy", int'(busy), 0);
    chk("st_queue_drained", exp_st.size(), 0);
    chk("blk_queue_drained", exp_blk.size(), 0);
  endtask

  task automatic run_msg(input int n, input int gap, input int stall);
    push_msg(n);
    stall_n = stall;
    start_msg();
    send_words(n, gap, 1'b1);
    wait_idle();
  endtask

  initial begin
    int tmo;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", int'({pkt_rdy, st_pkt, clr, pad_pkt, zero_pkt, mgln_pkt, blk_vld, blk_last, busy}), 0);
    @(negedge clk);
    rst_b = 1'b1;

    // asynchronous reset in the middle of the zero fill
    push_msg(3);
    start_msg();
    send_words(3, 0, 1'b1);
    tmo = 0;
    while (!zero_pkt && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    chk("reach_zero", int'(zero_pkt), 1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("async_reset_outputs", int'({pkt_rdy, st_pkt, clr, pad_pkt, zero_pkt, mgln_pkt, blk_vld, blk_last, busy}), 0);
    exp_st.delete();
    exp_blk.delete();
    repeat (2) @(negedge clk);
    rst_b = 1'b1;

    run_msg(3, 0, 0);
    run_msg(6, 0, 0);
    run_msg(7, 0, 0);
    run_msg(10, 1, 3);

`ifdef SHA2_PADCTRL_ABORT_EN
    for (int i = 0; i < 4; i++) exp_st.push_back(i);
    start_msg();
    send_words(4, 0, 1'b0);
    chk("abort_idx", int'(idx), 4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_clr", int'(clr), 1);
    @(negedge clk);
    chk("abort_idle_busy", int'(busy), 0);
    chk("abort_idle_clr", int'(clr), 0);
    chk("abort_idx_cleared", int'(idx), 0);
    run_msg(3, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
